user_access_arbiter: RTL and testbench
======================================

# user_access_arbiter

Round-robin access controller for the shared station resource. It accepts up to four user requests, indexed by the 2-bit user code produced by the user-conversion stage, and grants the resource to one user at a time. Each grant has a bounded hold time. Fairness comes from a rotating priority pointer, and a mandatory gap cycle separates consecutive owners. The block sits between the user-decode logic and the resource-enable datapath.

## Interface
Parameters:
- MAX_HOLD, 16, maximum grant length in cycles (≥ 2).
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD-1.

Ports:
- CLK  in  1  system clock; everything is rising-edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  4  request vector; bit i = user i (user code i).
- REL  in  1  voluntary release by the current owner; ignored outside GRANTED.
- GRANT  out  4  one-hot grant; all-zero when no owner.
- OWNER  out  2  index of the granted user; 0 when no owner.
- BUSY  out  1  high while in GRANTED.
- TIMEOUT  out  1  one-cycle pulse on a forced release.
- HOLD_CNT  out  CNT_W  cycles elapsed in the current grant.

## Operation
- FSM states: IDLE, GRANTED, GAP. Internal 2-bit priority pointer PTR.
- All outputs are registered.
- Reset (RST=1 at an edge):
  - state=IDLE, PTR=0.
  - GRANT=0000, OWNER=0, BUSY=0, TIMEOUT=0, HOLD_CNT=0.
  - Reset overrides every other input, including mid-grant.
- IDLE:
  - If REQ==0000, stay in IDLE.
  - Otherwise select the first set bit scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - Next state GRANTED: GRANT=onehot(sel), OWNER=sel, BUSY=1, HOLD_CNT=0.
- GRANTED, evaluated at each edge in this priority order:
  1. REL=1 → GAP, TIMEOUT=0.
  2. REQ[OWNER]=0 (owner withdrew) → GAP, TIMEOUT=0.
  3. HOLD_CNT==MAX_HOLD-1 → GAP, TIMEOUT=1.
  4. Otherwise stay in GRANTED, HOLD_CNT+1.
- On any exit from GRANTED: PTR=OWNER+1 (mod 4, wraps 3→0).
- Entering GAP: GRANT=0000, OWNER=0, BUSY=0, HOLD_CNT=0.
- GAP: lasts exactly one cycle, then unconditionally → IDLE. TIMEOUT drops to 0 on leaving GAP.
- Requests from non-owners during GRANTED or GAP are not latched. They must still be asserted when sampled in IDLE.
- REQ changes other than the owner's own bit have no effect while GRANTED.
- A simultaneous REL and timeout counts as a voluntary release: no TIMEOUT pulse.

## Timing
- Grant latency: REQ sampled high in IDLE at edge t → GRANT valid after edge t (one cycle).
- Maximum grant length: exactly MAX_HOLD cycles with BUSY=1 (HOLD_CNT runs 0..MAX_HOLD-1).
- Release latency: REL high at edge t → GRANT=0000 after edge t.
- TIMEOUT is high for exactly the single GAP cycle that follows a forced release.
- Turnaround: the last GRANTED cycle is followed by GAP (1 cycle), then IDLE (1 cycle, arbitration). The next GRANT is valid 2 cycles after the previous one drops.
- Back-to-back grants with REQ=1111 held: one grant every MAX_HOLD+2 cycles under timeout, or every (hold+2) cycles under REL.
- Invariants: GRANT is one-hot or zero; BUSY == |GRANT; GRANT[OWNER]==1 whenever BUSY=1.

## Test plan
- Basic grant: after reset, REQ=0010 → next cycle GRANT=0010, OWNER=1, BUSY=1, HOLD_CNT=0; REL pulse → next cycle GRANT=0000, TIMEOUT=0.
- Round robin: REQ=1111 held, REL pulsed 3 cycles into each grant → GRANT sequence 0001, 0010, 0100, 1000, 0001 (PTR wraps 3→0), each separated by 2 zero cycles.
- Timeout: MAX_HOLD=16, REQ=0001 held, REL=0 → BUSY high exactly 16 cycles (HOLD_CNT 0..15), TIMEOUT=1 for 1 cycle, then user 0 regranted 2 cycles after the drop.
- Release/timeout collision: REL=1 on the cycle HOLD_CNT=MAX_HOLD-1 → GAP with TIMEOUT=0; owner withdrawing REQ mid-grant → GAP next edge, TIMEOUT=0.
- Reset mid-grant: user 2 granted with HOLD_CNT=5, RST=1 for one edge → all outputs 0 after that edge; then REQ=1111 → GRANT=0001 (PTR reset to 0).
- Priority skip: PTR=3 after user 2 releases, REQ=0101 → GRANT=0001 (user 3 idle, scan wraps to 0).

Source files
------------

// File: rtl/user_access_arbiter.sv
// user_access_arbiter
// Round-robin owner selection for the shared station resource. Up to four
// users request access; one owner at a time holds the grant for a bounded
// number of cycles, and a one-cycle gap separates consecutive owners.
// All outputs come straight from registers.
module user_access_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       REQ,
    input  logic             REL,
    output logic [3:0]       GRANT,
    output logic [1:0]       OWNER,
    output logic             BUSY,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] HOLD_CNT
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANTED = 2'd1;
    localparam logic [1:0] S_GAP     = 2'd2;

    // Last legal value of the hold counter; reaching it forces a release.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [1:0] state;
    logic [1:0] ptr;

    logic       found;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       leave;
    logic       forced;

    // Rotating-priority scan: first requester at or after the pointer wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Exit conditions while granted; a release that coincides with the hold
    // limit is treated as voluntary, so only an unreleased, still-requesting
    // owner at the limit is reported as a timeout.
    always_comb begin
        leave  = REL || !REQ[OWNER] || (HOLD_CNT == HOLD_LAST);
        forced = !REL && REQ[OWNER] && (HOLD_CNT == HOLD_LAST);
    end

    // State, pointer and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            ptr      <= 2'd0;
            GRANT    <= 4'b0000;
            OWNER    <= 2'd0;
            BUSY     <= 1'b0;
            TIMEOUT  <= 1'b0;
            HOLD_CNT <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    TIMEOUT <= 1'b0;
                    if (found) begin
                        state    <= S_GRANTED;
                        GRANT    <= 4'b0001 << sel;
                        OWNER    <= sel;
                        BUSY     <= 1'b1;
                        HOLD_CNT <= '0;
                    end
                end
                S_GRANTED: begin
                    if (leave) begin
                        state    <= S_GAP;
                        ptr      <= OWNER + 2'd1;
                        GRANT    <= 4'b0000;
                        OWNER    <= 2'd0;
                        BUSY     <= 1'b0;
                        HOLD_CNT <= '0;
                        TIMEOUT  <= forced;
                    end else begin
                        HOLD_CNT <= HOLD_CNT + 1'b1;
                    end
                end
                S_GAP: begin
                    state   <= S_IDLE;
                    TIMEOUT <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    GRANT    <= 4'b0000;
                    OWNER    <= 2'd0;
                    BUSY     <= 1'b0;
                    TIMEOUT  <= 1'b0;
                    HOLD_CNT <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_access_arbiter.sv
// Testbench for user_access_arbiter: directed scenarios plus a randomized
// run, all compared against a behavioural model of the access rules.
module tb_user_access_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic [3:0]       REQ;
    logic             REL;
    logic [3:0]       GRANT;
    logic [1:0]       OWNER;
    logic             BUSY;
    logic             TIMEOUT;
    logic [CNT_W-1:0] HOLD_CNT;

    int checks = 0;
    int errors = 0;

    user_access_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REL(REL),
        .GRANT(GRANT), .OWNER(OWNER), .BUSY(BUSY),
        .TIMEOUT(TIMEOUT), .HOLD_CNT(HOLD_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    // Behavioural model: owner (-1 = none), cycles held, gap pending,
    // rotating pointer, and the timeout flag.
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;
    bit m_gap   = 0;
    bit m_to    = 0;

    function automatic void model_step();
        if (RST) begin
            m_owner = -1; m_hold = 0; m_ptr = 0; m_gap = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            if (REL || !REQ[m_owner] || m_hold == MAX_HOLD - 1) begin
                m_to    = !REL && REQ[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_hold  = 0;
                m_gap   = 1;
            end else begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 0;
            m_to  = 0;
        end else begin
            m_to = 0;
            for (int k = 0; k < 4; k++) begin
                int u;
                u = (m_ptr + k) % 4;
                if (REQ[u]) begin
                    m_owner = u;
                    m_hold  = 0;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [12:0] model_vec();
        logic [3:0] g;
        logic [1:0] o;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        o = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return {g, o, (m_owner >= 0), m_to, 5'(m_hold)};
    endfunction

    // Advance one clock: DUT and model see the same sampled inputs; outputs
    // are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        RST = 1; REQ = 4'b1111; REL = 0;
        tick();
        RST = 0; REQ = 4'b0000;
        checks++;
        if ({GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT});
        end
        tick();
        checks++;
        if (GRANT !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle_noreq: GRANT=%b want 0000", GRANT);
        end
    endtask

    task automatic test_basic_grant();
        REQ = 4'b0010;
        tick();
        checks++;
        if (GRANT !== 4'b0010 || OWNER !== 2'd1 || BUSY !== 1'b1 || HOLD_CNT !== 5'd0) begin
            errors++;
            $display("FAIL basic_grant: GRANT=%b OWNER=%0d BUSY=%b HOLD=%0d want 0010/1/1/0",
                     GRANT, OWNER, BUSY, HOLD_CNT);
        end
        REL = 1;
        tick();
        REL = 0;
        checks++;
        if (GRANT !== 4'b0000 || TIMEOUT !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: GRANT=%b TIMEOUT=%b BUSY=%b want 0000/0/0", GRANT, TIMEOUT, BUSY);
        end
        REQ = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq[$];
        int zeros;
        int bad_gap;
        RST = 1; tick(); RST = 0;
        REQ = 4'b1111;
        zeros = 0; bad_gap = 0;
        for (int c = 0; c < 60 && seq.size() < 5; c++) begin
            tick();
            checks++;
            if ({GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT} !== model_vec()) begin
                errors++;
                $display("FAIL rr_cycle%0d: got %h want %h", c, {GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT}, model_vec());
            end
            if (BUSY === 1'b1 && HOLD_CNT === 5'd0) begin
                if (seq.size() > 0 && zeros != 2) bad_gap++;
                seq.push_back(GRANT);
                zeros = 0;
            end else if (BUSY === 1'b0) begin
                zeros++;
            end
            REL = (BUSY === 1'b1 && HOLD_CNT === 5'd2);
        end
        REL = 0;
        checks++;
        if (seq.size() != 5 || seq[0] !== 4'b0001 || seq[1] !== 4'b0010 ||
            seq[2] !== 4'b0100 || seq[3] !== 4'b1000 || seq[4] !== 4'b0001) begin
            errors++;
            $display("FAIL rr_sequence: got %0d grants %p want 1,2,4,8,1", seq.size(), seq);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL rr_gap: %0d gaps not equal to 2 cycles, want 0", bad_gap);
        end
    endtask

    task automatic test_timeout();
        int busy_cnt;
        int to_cnt;
        bit done;
        RST = 1; tick(); RST = 0;
        REQ = 4'b0001; REL = 0;
        busy_cnt = 0; to_cnt = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            checks++;
            if ({GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT} !== model_vec()) begin
                errors++;
                $display("FAIL to_cycle%0d: got %h want %h", c, {GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT}, model_vec());
            end
            if (BUSY === 1'b1) busy_cnt++;
            if (BUSY === 1'b0 && busy_cnt > 0) done = 1;
        end
        checks++;
        if (busy_cnt != MAX_HOLD) begin
            errors++;
            $display("FAIL timeout_length: busy %0d cycles want %0d", busy_cnt, MAX_HOLD);
        end
        checks++;
        if (TIMEOUT !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: TIMEOUT=%b want 1", TIMEOUT);
        end
        tick();
        checks++;
        if (TIMEOUT !== 1'b0 || GRANT !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_drop: TIMEOUT=%b GRANT=%b want 0/0000", TIMEOUT, GRANT);
        end
        tick();
        checks++;
        if (GRANT !== 4'b0001 || HOLD_CNT !== 5'd0) begin
            errors++;
            $display("FAIL timeout_regrant: GRANT=%b HOLD=%0d want 0001/0", GRANT, HOLD_CNT);
        end
    endtask

    task automatic test_collision();
        RST = 1; tick(); RST = 0;
        REQ = 4'b1000; REL = 0;
        tick();
        for (int c = 0; c < 40 && HOLD_CNT !== 5'(MAX_HOLD - 1); c++) tick();
        REL = 1;
        tick();
        REL = 0;
        checks++;
        if (GRANT !== 4'b0000 || TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL collision_rel: GRANT=%b TIMEOUT=%b want 0000/0", GRANT, TIMEOUT);
        end
        tick(); tick();
        checks++;
        if (GRANT !== 4'b1000) begin
            errors++;
            $display("FAIL collision_regrant: GRANT=%b want 1000", GRANT);
        end
        tick(); tick(); tick();
        REQ = 4'b0000;
        tick();
        checks++;
        if (GRANT !== 4'b0000 || TIMEOUT !== 1'b0 || HOLD_CNT !== 5'd0) begin
            errors++;
            $display("FAIL withdraw: GRANT=%b TIMEOUT=%b HOLD=%0d want 0000/0/0", GRANT, TIMEOUT, HOLD_CNT);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid_grant();
        RST = 1; tick(); RST = 0;
        REQ = 4'b0100; REL = 0;
        tick();
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (GRANT !== 4'b0100 || HOLD_CNT !== 5'd5) begin
            errors++;
            $display("FAIL midgrant_setup: GRANT=%b HOLD=%0d want 0100/5", GRANT, HOLD_CNT);
        end
        RST = 1;
        tick();
        RST = 0;
        checks++;
        if ({GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT} !== 13'd0) begin
            errors++;
            $display("FAIL midgrant_reset: got %h want 0", {GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT});
        end
        REQ = 4'b1111;
        tick();
        checks++;
        if (GRANT !== 4'b0001 || OWNER !== 2'd0) begin
            errors++;
            $display("FAIL midgrant_ptr: GRANT=%b OWNER=%0d want 0001/0", GRANT, OWNER);
        end
    endtask

    task automatic test_priority_skip();
        RST = 1; tick(); RST = 0;
        REQ = 4'b0100; REL = 0;
        tick();
        REL = 1; REQ = 4'b0101;
        tick();
        REL = 0;
        tick();
        tick();
        checks++;
        if (GRANT !== 4'b0001 || OWNER !== 2'd0) begin
            errors++;
            $display("FAIL priority_skip: GRANT=%b OWNER=%0d want 0001/0", GRANT, OWNER);
        end
    endtask

    task automatic test_random();
        RST = 1; tick(); RST = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) REQ = 4'($urandom);
            REL = ($urandom_range(0, 15) == 0);
            RST = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if ({GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT} !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", c, {GRANT, OWNER, BUSY, TIMEOUT, HOLD_CNT}, model_vec());
            end
            checks++;
            if (BUSY !== (|GRANT) || (BUSY === 1'b1 && GRANT[OWNER] !== 1'b1) || $countones(GRANT) > 1) begin
                errors++;
                $display("FAIL random_invariant%0d: GRANT=%b OWNER=%0d BUSY=%b", c, GRANT, OWNER, BUSY);
            end
        end
        RST = 0; REL = 0;
    endtask

    initial begin
        RST = 1; REQ = 4'b0000; REL = 0;
        #1;
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_timeout();
        test_collision();
        test_reset_mid_grant();
        test_priority_skip();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
